// File: rtl/axi_rdata_router_if.sv
// R-channel bundle. The master modport drives beats, the slave modport accepts them.
// The same interface serves the tagged slave side and the untagged master side.
interface axi_rdata_router_if #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (output rid, rdata, rresp, rlast, rvalid, input rready);
    modport slave  (input rid, rdata, rresp, rlast, rvalid, output rready);
endinterface

// File: rtl/axi_rdata_router.sv
// R-channel return path: merges beats from two slaves and steers each one to the master
// named by the tag in RID[ID_W+3:ID_W]. Bursts are locked until RLAST; round-robin between bursts.
//   state   | meaning
//   IDLE    | no burst owns the path; grant follows RVALID and prio
//   LOCK_S0 | S0 owns the path until its RLAST handshake
//   LOCK_S1 | S1 owns the path until its RLAST handshake
module axi_rdata_router #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    axi_rdata_router_if.slave       i_s0,
    axi_rdata_router_if.slave       i_s1,
    axi_rdata_router_if.master      o_m0,
    axi_rdata_router_if.master      o_m1,
    output logic                    o_route_err
);
    localparam int IDS_W = ID_W + 4;

    typedef enum logic [1:0] {IDLE, LOCK_S0, LOCK_S1} state_t;

    state_t r_state;
    logic   r_prio;
    logic   r_route_err;

    logic              w_gnt;
    logic              w_sel;
    logic [IDS_W-1:0]  w_id;
    logic [DATA_W-1:0] w_data;
    logic [1:0]        w_resp;
    logic              w_last;
    logic              w_valid;
    logic              w_to_m0;
    logic              w_to_m1;
    logic              w_ready;
    logic              w_hs;

    always_comb begin
        w_gnt = 1'b0;
        w_sel = 1'b0;
        case (r_state)
            LOCK_S0: w_gnt = 1'b1;
            LOCK_S1: begin
                w_gnt = 1'b1;
                w_sel = 1'b1;
            end
            default: begin
                w_gnt = i_s0.rvalid | i_s1.rvalid;
                w_sel = (i_s0.rvalid & i_s1.rvalid) ? r_prio : i_s1.rvalid;
            end
        endcase
    end

    assign w_id    = w_sel ? i_s1.rid   : i_s0.rid;
    assign w_data  = w_sel ? i_s1.rdata : i_s0.rdata;
    assign w_resp  = w_sel ? i_s1.rresp : i_s0.rresp;
    assign w_last  = w_sel ? i_s1.rlast : i_s0.rlast;
    assign w_valid = w_gnt & (w_sel ? i_s1.rvalid : i_s0.rvalid);

    // Outputs are forced quiet while reset is held, independent of the clock.
    assign w_to_m0 = w_gnt & ~rst & (w_id[IDS_W-1:ID_W] == 4'b0001);
    assign w_to_m1 = w_gnt & ~rst & (w_id[IDS_W-1:ID_W] == 4'b0010);
    assign w_ready = w_to_m0 ? o_m0.rready : (w_to_m1 ? o_m1.rready : 1'b1);
    assign w_hs    = w_gnt & ~rst & w_valid & w_ready;

    assign i_s0.rready = ~rst & w_gnt & ~w_sel & w_ready;
    assign i_s1.rready = ~rst & w_gnt &  w_sel & w_ready;

    assign o_m0.rvalid = w_to_m0 & w_valid;
    assign o_m0.rid    = w_to_m0 ? w_id[ID_W-1:0] : '0;
    assign o_m0.rdata  = w_to_m0 ? w_data : '0;
    assign o_m0.rresp  = w_to_m0 ? w_resp : '0;
    assign o_m0.rlast  = w_to_m0 & w_last;

    assign o_m1.rvalid = w_to_m1 & w_valid;
    assign o_m1.rid    = w_to_m1 ? w_id[ID_W-1:0] : '0;
    assign o_m1.rdata  = w_to_m1 ? w_data : '0;
    assign o_m1.rresp  = w_to_m1 ? w_resp : '0;
    assign o_m1.rlast  = w_to_m1 & w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prio      <= 1'b0;
            r_route_err <= 1'b0;
        end else begin
            if (w_hs & ~w_to_m0 & ~w_to_m1) begin
                r_route_err <= 1'b1;
            end
            if (w_hs & w_last) begin
                r_state <= IDLE;
                r_prio  <= ~w_sel;
            end else if (w_gnt) begin
                r_state <= w_sel ? LOCK_S1 : LOCK_S0;
            end
        end
    end

    assign o_route_err = r_route_err;
endmodule

// File: tb/tb_axi_rdata_router.sv
// Random two-slave R traffic against a burst-ownership reference model; a negedge monitor
// checks routing, grant order and route_err each cycle and pops a per-slave scoreboard on every accept.
module tb_axi_rdata_router;
    localparam int ID_W   = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic route_err;

    always #5 clk = ~clk;

    axi_rdata_router_if #(.ID_W(ID_W + 4), .DATA_W(DATA_W)) s0();
    axi_rdata_router_if #(.ID_W(ID_W + 4), .DATA_W(DATA_W)) s1();
    axi_rdata_router_if #(.ID_W(ID_W),     .DATA_W(DATA_W)) m0();
    axi_rdata_router_if #(.ID_W(ID_W),     .DATA_W(DATA_W)) m1();

    axi_rdata_router #(.ID_W(ID_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_s0        (s0),
        .i_s1        (s1),
        .o_m0        (m0),
        .o_m1        (m1),
        .o_route_err (route_err)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    int    rdy_pct = 100;
    beat_t q0[$];
    beat_t q1[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_s(input int s, input logic v, input beat_t b);
        if (s == 0) begin
            s0.rvalid = v; s0.rid = b.id; s0.rdata = b.data; s0.rresp = b.resp; s0.rlast = b.last;
        end else begin
            s1.rvalid = v; s1.rid = b.id; s1.rdata = b.data; s1.rresp = b.resp; s1.rlast = b.last;
        end
    endtask

    task automatic drive_slave(input int s, input int nb, input int maxlen, input int maxgap, input bit bad);
        beat_t      b;
        int         len;
        int         cnt;
        int         t;
        logic [3:0] tag;
        logic [3:0] idl;
        bit         acc;
        b = '0;
        for (int k = 0; k < nb; k++) begin
            set_s(s, 1'b0, b);
            repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
            len = $urandom_range(1, maxlen);
            t   = $urandom_range(0, 9);
            if (!bad || t < 8) tag = 4'($urandom_range(1, 2));
            else begin
                tag = 4'($urandom_range(0, 15));
                if (tag == 4'd1 || tag == 4'd2) tag = 4'hF;
            end
            idl = 4'($urandom);
            for (int i = 0; i < len; i++) begin
                if (i > 0 && $urandom_range(0, 4) == 0) begin
                    set_s(s, 1'b0, b);
                    @(posedge clk); #1;
                end
                b.id   = {tag, idl};
                b.data = $urandom;
                b.resp = 2'($urandom);
                b.last = (i == len - 1);
                set_s(s, 1'b1, b);
                if (s == 0) q0.push_back(b); else q1.push_back(b);
                cnt = 0;
                do begin
                    @(negedge clk);
                    acc = (s == 0) ? s0.rready : s1.rready;
                    @(posedge clk); #1;
                    cnt++;
                end while (!acc && cnt < 500);
                chk("beat_accept_in_budget", 64'(acc), 64'd1);
            end
        end
        set_s(s, 1'b0, b);
    endtask

    initial begin
        m0.rready = 1'b0;
        m1.rready = 1'b0;
        forever begin
            @(posedge clk); #1;
            m0.rready = ($urandom_range(0, 99) < rdy_pct);
            m1.rready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Reference model: which slave owns the path, and who is preferred when both start together.
    int          own = -1;
    int          pref = 0;
    bit          err_exp = 1'b0;
    int          g;
    bit          bv;
    bit          r;
    bit          acc_m;
    logic [7:0]  bid;
    logic [3:0]  tag_m;
    logic [39:0] fields;
    logic [39:0] exp_m0;
    logic [39:0] exp_m1;
    logic [1:0]  exp_rdy;
    beat_t       bb;
    beat_t       pb;

    function automatic logic [39:0] mvec0();
        return {m0.rvalid, m0.rid, m0.rdata, m0.rresp, m0.rlast};
    endfunction

    function automatic logic [39:0] mvec1();
        return {m1.rvalid, m1.rid, m1.rdata, m1.rresp, m1.rlast};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs", {mvec0(), mvec1(), s0.rready, s1.rready}, 64'd0);
            chk("reset_route_err", 64'(route_err), 64'd0);
            own = -1; pref = 0; err_exp = 1'b0;
            q0.delete(); q1.delete();
        end else begin
            chk("route_err", 64'(route_err), 64'(err_exp));
            if (own >= 0) g = own;
            else if (s0.rvalid && s1.rvalid) g = pref;
            else if (s0.rvalid) g = 0;
            else if (s1.rvalid) g = 1;
            else g = -1;
            exp_m0 = '0; exp_m1 = '0; exp_rdy = 2'b00; acc_m = 1'b0;
            if (g >= 0) begin
                bb    = (g == 0) ? beat_t'{s0.rid, s0.rdata, s0.rresp, s0.rlast}
                                 : beat_t'{s1.rid, s1.rdata, s1.rresp, s1.rlast};
                bv    = (g == 0) ? s0.rvalid : s1.rvalid;
                bid   = bb.id;
                tag_m = bid[7:4];
                fields = {bv, bid[3:0], bb.data, bb.resp, bb.last};
                if (tag_m == 4'd1) begin exp_m0 = fields; r = m0.rready; end
                else if (tag_m == 4'd2) begin exp_m1 = fields; r = m1.rready; end
                else r = 1'b1;
                exp_rdy[g] = r;
                acc_m = bv && r;
            end
            chk("m0_outputs", 64'(mvec0()), 64'(exp_m0));
            chk("m1_outputs", 64'(mvec1()), 64'(exp_m1));
            chk("slave_readies", 64'({s1.rready, s0.rready}), 64'(exp_rdy));
            if (acc_m) begin
                chk("scoreboard_nonempty", 64'((g == 0) ? (q0.size() != 0) : (q1.size() != 0)), 64'd1);
                if ((g == 0 && q0.size() != 0) || (g == 1 && q1.size() != 0)) begin
                    pb = (g == 0) ? q0.pop_front() : q1.pop_front();
                    if (pb.id[7:4] == 4'd1)
                        chk("m0_beat", 64'({m0.rid, m0.rdata, m0.rresp, m0.rlast}),
                            64'({pb.id[3:0], pb.data, pb.resp, pb.last}));
                    else if (pb.id[7:4] == 4'd2)
                        chk("m1_beat", 64'({m1.rid, m1.rdata, m1.rresp, m1.rlast}),
                            64'({pb.id[3:0], pb.data, pb.resp, pb.last}));
                    else
                        err_exp = 1'b1;
                end
            end
            if (g >= 0) begin
                if (acc_m && bb.last) begin
                    own  = -1;
                    pref = 1 - g;
                end else begin
                    own = g;
                end
            end
        end
    end

    initial begin
        beat_t b;
        b = '0;
        set_s(0, 1'b0, b);
        set_s(1, 1'b0, b);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back single beats from both slaves with full readiness: strict alternation.
        rdy_pct = 100;
        fork
            drive_slave(0, 8, 1, 0, 1'b0);
            drive_slave(1, 8, 1, 0, 1'b0);
        join

        rdy_pct = 70;
        fork
            drive_slave(0, 40, 4, 3, 1'b1);
            drive_slave(1, 40, 4, 3, 1'b1);
        join

        // Asynchronous reset during the second beat of an S1 burst.
        rdy_pct = 100;
        repeat (2) begin @(posedge clk); #1; end
        b.id = 8'h25; b.data = 32'hA5A5_0001; b.resp = 2'b00; b.last = 1'b0;
        set_s(1, 1'b1, b);
        q1.push_back(b);
        @(posedge clk); #1;
        b.data = 32'hA5A5_0002;
        set_s(1, 1'b1, b);
        q1.push_back(b);
        #1 rst = 1'b1;
        #1 chk("async_reset_quiet", {mvec0(), mvec1(), s0.rready, s1.rready}, 64'd0);
        @(posedge clk); #1;
        set_s(1, 1'b0, b);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        rdy_pct = 50;
        fork
            drive_slave(0, 30, 4, 2, 1'b1);
            drive_slave(1, 30, 4, 2, 1'b1);
        join
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/axi_rdata_router.md
Name: axi_rdata_router

Overview:
- Read-data (R) channel return path of the AXI bridge: merges R beats from two slaves and steers each beat back to the originating master.
- The target master is chosen from the master tag carried in the upper 4 bits of the extended ID (IDS).
- A burst from the granted slave is held until its RLAST beat is accepted. Slave choice between bursts is round-robin.
- Sits between the slave-side R ports and master-side R ports, opposite the address-channel arbiter.

Parameters:
- ID_W, 4, master-side ID width; slave-side IDS width is ID_W+4.
- DATA_W, 32, RDATA width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- RID_S0  in  ID_W+4  S0 extended ID {tag, id}
- RDATA_S0  in  DATA_W  S0 read data
- RRESP_S0  in  2  S0 response
- RLAST_S0  in  1  S0 last beat
- RVALID_S0  in  1  S0 valid
- RREADY_S0  out  1  S0 ready
- RID_S1, RDATA_S1, RRESP_S1, RLAST_S1, RVALID_S1  in  (same widths)  S1 R channel
- RREADY_S1  out  1  S1 ready
- RID_M0  out  ID_W  M0 ID (tag stripped)
- RDATA_M0  out  DATA_W  M0 read data
- RRESP_M0  out  2  M0 response
- RLAST_M0  out  1  M0 last beat
- RVALID_M0  out  1  M0 valid
- RREADY_M0  in  1  M0 ready
- RID_M1, RDATA_M1, RRESP_M1, RLAST_M1, RVALID_M1  out  (same widths)  M1 R channel
- RREADY_M1  in  1  M1 ready
- route_err  out  1  sticky flag: a beat carried an unknown tag

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, prio=0 (S0 preferred), route_err=0.
  - All VALID/READY outputs are 0. All data/ID outputs are 0.
- Zero latency: the selected slave's beat is presented to the master combinationally in the same cycle. No storage.
- Grant selection:
  - IDLE: grant = the valid slave. If both are valid, grant = S0 when prio=0, S1 when prio=1.
  - LOCK_Sx: grant = Sx regardless of the other slave's valid.
- Routing of the granted slave's RID[ID_W+3:ID_W]:
  - 4'b0001 -> M0.
  - 4'b0010 -> M1.
  - Any other value -> no master. RREADY_Sx=1 (beat sunk) and route_err is set on the handshake.
- Routed master signals:
  - RVALID_Mk = RVALID_Sx.
  - RID_Mk = RID_Sx[ID_W-1:0].
  - RDATA/RRESP/RLAST pass through unchanged.
  - RREADY_Sx = RREADY_Mk.
- Non-granted slave sees RREADY=0. Non-target master sees RVALID=0 and all-zero data, ID, RESP and LAST.
- Handshake (hs) = granted RVALID & RREADY.
- FSM transitions (registered):
  - IDLE -> LOCK_Sx when a grant exists and not (hs & RLAST). This covers an unaccepted first beat and a multi-beat burst, so the grant stays stable while VALID is held.
  - IDLE stays IDLE on hs & RLAST (single-beat burst). prio <= ~x.
  - LOCK_Sx -> IDLE on hs & RLAST. prio <= ~x.
  - LOCK_Sx otherwise stays LOCK_Sx. A deasserted RVALID_Sx inside a lock does not release it.
- Simultaneous valid: the other slave waits unaccepted (RREADY=0) until the burst completes. It then wins at once on the next cycle, because prio has flipped.
- route_err is cleared only by rst.
- Reset asserted mid-burst: immediate return to IDLE with prio=0. The partially delivered burst is abandoned; no recovery.

Test Plan:
- Single beat, no contention:
  - Stimulus: S0 drives RID=8'h13, RDATA=32'hDEADBEEF, RLAST=1, RVALID=1; RREADY_M0=1.
  - Required response: same cycle RVALID_M0=1, RID_M0=4'h3, RREADY_S0=1, M1 idle. Next cycle state=IDLE, prio=1.
- Burst lock:
  - Stimulus: S1 sends a 4-beat burst, RID=8'h25. S0 asserts RVALID at beat 2.
  - Required response: all 4 beats reach M1 with RID_M1=4'h5; RREADY_S0=0 throughout. The S0 beat is accepted in the cycle after S1's RLAST handshake.
- Round-robin:
  - Stimulus: S0 and S1 both hold single-beat RLAST=1 traffic continuously from reset.
  - Required response: grants alternate S0, S1, S0, S1 on consecutive cycles.
- Backpressure:
  - Stimulus: S0 beat to M1 with RREADY_M1=0 for 3 cycles, S1 also valid.
  - Required response: state enters LOCK_S0, RVALID_M1 stays 1 with stable data, and S1 is never granted until the S0 RLAST handshake.
- Unknown tag:
  - Stimulus: S0 beat with RID=8'h47.
  - Required response: RVALID_M0=RVALID_M1=0, RREADY_S0=1, route_err=1 from the next cycle, and it stays set.
- Mid-burst reset:
  - Stimulus: assert rst asynchronously during beat 2 of a 4-beat S1 burst.
  - Required response: all VALID/READY outputs are 0 immediately; after release, state=IDLE, prio=0, route_err=0.
